// File: rtl/fpga_link_param.sv
// Full-duplex async serial link: framed TX shifter and oversampled RX.
// Define FPGA_LINK_PARITY_EN to append and check an even-parity bit.
module fpga_link_param #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  tx_line,
    input  logic                  rx_line,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  received,
    input  logic                  processed,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef FPGA_LINK_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef FPGA_LINK_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    tx_state_t             tx_state, tx_next;
    logic [CW-1:0]         tx_cnt, tx_cnt_next;
    logic [IW-1:0]         tx_idx, tx_idx_next;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_next;
    logic                  tx_bit_end;

    rx_state_t             rx_state, rx_next;
    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic [CW-1:0]         rx_cnt, rx_cnt_next;
    logic [IW-1:0]         rx_idx, rx_idx_next;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_next;
    logic                  rx_wait, rx_wait_next;
    logic                  rx_bad;
    logic [DATA_WIDTH-1:0] data_out_next;
    logic                  received_next;
    logic                  overrun_next;
    logic                  ferr_next;

`ifdef FPGA_LINK_PARITY_EN
    logic                  tx_par, tx_par_next;
    logic                  rx_perr, rx_perr_next;
    assign rx_bad = !rx_s || rx_perr;
`else
    assign rx_bad = !rx_s;
`endif

    assign rx_s       = rx_sync[1];
    assign tx_bit_end = (tx_cnt == CNT_LAST);

    always_comb begin
        tx_next       = tx_state;
        tx_cnt_next   = tx_bit_end ? '0 : tx_cnt + 1'b1;
        tx_idx_next   = tx_idx;
        tx_shift_next = tx_shift;
        busy          = 1'b1;
        tx_line       = 1'b1;
`ifdef FPGA_LINK_PARITY_EN
        tx_par_next   = tx_par;
`endif
        unique case (tx_state)
            TX_IDLE: begin
                busy        = 1'b0;
                tx_cnt_next = '0;
                if (start) begin
                    tx_next       = TX_START;
                    tx_shift_next = data_in;
`ifdef FPGA_LINK_PARITY_EN
                    tx_par_next   = ^data_in;
`endif
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) begin
                    tx_next     = TX_DATA;
                    tx_idx_next = '0;
                end
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end) begin
                    tx_shift_next = tx_shift >> 1;
                    tx_idx_next   = tx_idx + 1'b1;
                    if (tx_idx == IDX_LAST) begin
`ifdef FPGA_LINK_PARITY_EN
                        tx_next = TX_PARITY;
`else
                        tx_next = TX_STOP;
`endif
                    end
                end
            end
`ifdef FPGA_LINK_PARITY_EN
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) tx_next = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (tx_bit_end) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_next       = rx_state;
        rx_cnt_next   = rx_cnt + 1'b1;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        rx_wait_next  = rx_wait;
        data_out_next = data_out;
        received_next = received;
        overrun_next  = overrun;
        ferr_next     = 1'b0;
`ifdef FPGA_LINK_PARITY_EN
        rx_perr_next  = rx_perr;
`endif
        if (processed && received) begin
            received_next = 1'b0;
            overrun_next  = 1'b0;
        end
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (!rx_s) rx_next = RX_START;
            end
            RX_START: begin
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_next = '0;
                    rx_idx_next = '0;
                    rx_next     = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_idx_next   = rx_idx + 1'b1;
                    rx_shift_next = DATA_WIDTH'({rx_s, rx_shift} >> 1);
                    if (rx_idx == IDX_LAST) begin
`ifdef FPGA_LINK_PARITY_EN
                        rx_next = RX_PARITY;
`else
                        rx_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef FPGA_LINK_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_next  = '0;
                    rx_perr_next = rx_s != ^rx_shift;
                    rx_next      = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_wait) begin
                    // a low stop bit may be a break; hold off until the line idles
                    rx_cnt_next = '0;
                    if (rx_s) begin
                        rx_wait_next = 1'b0;
                        rx_next      = RX_IDLE;
                    end
                end else if (rx_cnt == CNT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_bad) begin
                        ferr_next    = 1'b1;
                        rx_wait_next = !rx_s;
                        if (rx_s) rx_next = RX_IDLE;
                    end else begin
                        rx_next = RX_IDLE;
                        if (received && !processed) begin
                            overrun_next = 1'b1;
                        end else begin
                            data_out_next = rx_shift;
                            received_next = 1'b1;
                        end
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            rx_state    <= RX_IDLE;
            rx_sync     <= 2'b11;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            rx_wait     <= 1'b0;
            data_out    <= '0;
            received    <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
`ifdef FPGA_LINK_PARITY_EN
            tx_par      <= 1'b0;
            rx_perr     <= 1'b0;
`endif
        end else begin
            tx_state    <= tx_next;
            tx_cnt      <= tx_cnt_next;
            tx_idx      <= tx_idx_next;
            tx_shift    <= tx_shift_next;
            rx_state    <= rx_next;
            rx_sync     <= {rx_sync[0], rx_line};
            rx_cnt      <= rx_cnt_next;
            rx_idx      <= rx_idx_next;
            rx_shift    <= rx_shift_next;
            rx_wait     <= rx_wait_next;
            data_out    <= data_out_next;
            received    <= received_next;
            overrun     <= overrun_next;
            frame_error <= ferr_next;
`ifdef FPGA_LINK_PARITY_EN
            tx_par      <= tx_par_next;
            rx_perr     <= rx_perr_next;
`endif
        end
    end

endmodule

// File: tb/tb_fpga_link_param.sv
// Bench for fpga_link_param: loopback and hand-driven frames vs a frame model.
// Build with FPGA_LINK_PARITY_EN to exercise the 12-bit parity configuration.
module tb_fpga_link_param;

`ifdef FPGA_LINK_PARITY_EN
    localparam int DW = 12;
    localparam int P  = 1;
`else
    localparam int DW = 8;
    localparam int P  = 0;
`endif
    localparam int BC = 4;
    localparam int NB = 2 + DW + P;
    localparam int N  = NB * BC;
    localparam logic [31:0] MASK = (32'd1 << DW) - 32'd1;

    logic          clock;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          start;
    logic          busy;
    logic          tx_line;
    logic          rx_line;
    logic [DW-1:0] data_out;
    logic          received;
    logic          processed;
    logic          frame_error;
    logic          overrun;

    logic loop;
    logic rx_drv;
    assign rx_line = loop ? tx_line : rx_drv;

    fpga_link_param #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in),
        .start(start),
        .busy(busy),
        .tx_line(tx_line),
        .rx_line(rx_line),
        .data_out(data_out),
        .received(received),
        .processed(processed),
        .frame_error(frame_error),
        .overrun(overrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int lat = 0;
    int fe_count = 0;
    int fe0;
    logic [31:0] m_data;
    logic        m_rcv;
    logic        m_ovr;
    logic [31:0] w1, w2;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    always @(posedge clock) if (frame_error === 1'b1) fe_count++;

    task automatic tick;
        @(negedge clock);
        cyc++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Bit b of a frame carrying w: start, data LSB first, parity, stop.
    function automatic logic exp_bit(int b, logic [31:0] w);
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (P == 1 && b == DW + 1) return ^w[DW-1:0];
        return 1'b1;
    endfunction

    task automatic check_frame(logic [31:0] w);
        for (int i = 0; i < N; i++) begin
            chk("tx_busy", 32'(busy), 32'd1);
            chk("tx_line", 32'(tx_line), 32'(exp_bit(i / BC, w)));
            tick();
        end
        chk("tx_busy_end", 32'(busy), 32'd0);
        chk("tx_idle_line", 32'(tx_line), 32'd1);
    endtask

    task automatic send_frame(logic [31:0] w);
        t0 = cyc;
        data_in = w[DW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check_frame(w);
    endtask

    task automatic settle;
        while (cyc - t0 < lat + 2) tick();
    endtask

    task automatic model_rx(logic [31:0] w);
        if (!m_rcv) begin
            m_data = w;
            m_rcv = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, "_received"}, 32'(received), 32'(m_rcv));
        chk({tag, "_data_out"}, 32'(data_out), m_data);
        chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic ack;
        processed = 1'b1;
        tick();
        processed = 1'b0;
        if (m_rcv) begin
            m_rcv = 1'b0;
            m_ovr = 1'b0;
        end
        check_model("ack");
    endtask

    task automatic drive_rx(logic [31:0] w, logic stop_bit, logic flip_par);
        logic b_val;
        for (int b = 0; b < NB; b++) begin
            b_val = exp_bit(b, w);
            if (b == NB - 1) b_val = stop_bit;
            if (P == 1 && b == DW + 1 && flip_par) b_val = ~b_val;
            rx_drv = b_val;
            repeat (BC) tick();
        end
        rx_drv = 1'b1;
        repeat (3 * BC) tick();
    endtask

    initial begin
        int seq[10] = '{2, 4, 8, 16, 32, 64, 128, 255, 99, 3};
        reset = 1'b1;
        start = 1'b0;
        processed = 1'b0;
        data_in = '0;
        rx_drv = 1'b1;
        loop = 1'b1;
        m_data = '0;
        m_rcv = 1'b0;
        m_ovr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_line", 32'(tx_line), 32'd1);
        chk("rst_ferr", 32'(frame_error), 32'd0);
        check_model("rst");

        // first loopback frame also yields the start-to-received latency
        send_frame(32'd45);
        for (int i = 0; i < 4 * N && received !== 1'b1; i++) tick();
        chk("rx45_arrived", 32'(received), 32'd1);
        lat = cyc - t0;
        model_rx(32'd45);
        check_model("rx45");
        ack();

        foreach (seq[i]) begin
            send_frame(32'(seq[i]) & MASK);
            settle();
            model_rx(32'(seq[i]) & MASK);
            check_model("seq");
            ack();
        end

        send_frame(32'd7);
        settle();
        model_rx(32'd7);
        check_model("ovr_first");
        send_frame(32'd9);
        settle();
        model_rx(32'd9);
        check_model("ovr_second");
        ack();

        // acknowledge lands on the same edge the next word completes
        send_frame(32'h11);
        settle();
        model_rx(32'h11);
        check_model("coin_a");
        t0 = cyc;
        data_in = DW'(32'h22);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc - t0 < lat - 1) tick();
        processed = 1'b1;
        tick();
        processed = 1'b0;
        m_data = 32'h22;
        m_rcv = 1'b1;
        m_ovr = 1'b0;
        check_model("coin_b");
        tick();
        check_model("coin_hold");
        ack();

        repeat (12) begin
            w1 = $urandom & MASK;
            send_frame(w1);
            settle();
            model_rx(w1);
            check_model("rand");
            if ($urandom_range(0, 1) == 1) ack();
        end
        ack();

        // start held high: second word begins right after the first
        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (2) tick();
        w1 = $urandom & MASK;
        w2 = ~w1 & MASK;
        data_in = w1[DW-1:0];
        start = 1'b1;
        tick();
        data_in = w2[DW-1:0];
        check_frame(w1);
        tick();
        start = 1'b0;
        check_frame(w2);
        check_model("held_start");

        fe0 = fe_count;
        drive_rx(32'hA5, 1'b0, 1'b0);
        chk("bad_stop_pulses", 32'(fe_count - fe0), 32'd1);
        check_model("bad_stop");
        fe0 = fe_count;
        rx_drv = 1'b0;
        repeat (2) tick();
        rx_drv = 1'b1;
        repeat (3 * BC) tick();
        chk("glitch_pulses", 32'(fe_count - fe0), 32'd0);
        check_model("glitch");
        drive_rx(32'h5A, 1'b1, 1'b0);
        model_rx(32'h5A);
        check_model("manual_good");
`ifdef FPGA_LINK_PARITY_EN
        ack();
        fe0 = fe_count;
        drive_rx(32'hABC, 1'b1, 1'b1);
        chk("bad_par_pulses", 32'(fe_count - fe0), 32'd1);
        check_model("bad_par");
        loop = 1'b1;
        send_frame(32'hABC);
        settle();
        model_rx(32'hABC);
        check_model("par_loop");
`endif
        loop = 1'b1;

        // reset mid-frame, with start and processed also asserted
        data_in = DW'(32'h3C);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        fe0 = fe_count;
        reset = 1'b1;
        start = 1'b1;
        processed = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        processed = 1'b0;
        m_data = '0;
        m_rcv = 1'b0;
        m_ovr = 1'b0;
        chk("midrst_tx_line", 32'(tx_line), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        check_model("midrst");
        repeat (N + lat) tick();
        chk("midrst_busy_later", 32'(busy), 32'd0);
        chk("midrst_pulses", 32'(fe_count - fe0), 32'd0);
        check_model("midrst_later");
        send_frame(32'h81 & MASK);
        settle();
        model_rx(32'h81 & MASK);
        check_model("after_rst");
        ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpga_link_param.md
FPGA_LINK_PARAM -- requirements
Module: fpga_link_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame, range 1..32.
REQ-002 Parameter BIT_CYCLES, default 4: clock cycles per serial bit, even, minimum 4.
REQ-003 clock  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH  transmit word, sampled when start is accepted.
REQ-006 start  input  1  transmit request, accepted only while busy=0.
REQ-007 busy  output  1  transmitter occupied with a frame.
REQ-008 tx_line  output  1  serial output, idle high.
REQ-009 rx_line  input  1  serial input, asynchronous, idle high.
REQ-010 data_out  output  DATA_WIDTH  last accepted received word.
REQ-011 received  output  1  data_out valid and unacknowledged.
REQ-012 processed  input  1  consumer acknowledge for received.
REQ-013 frame_error  output  1  one-cycle pulse on bad stop bit (or parity, if enabled).
REQ-014 overrun  output  1  sticky: a good frame completed while received=1.

Function
REQ-015 Frame on tx_line: start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, stop bit 1; each bit held exactly BIT_CYCLES cycles.
REQ-016 TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_PARITY (PARITY_EN only), TX_STOP.
REQ-017 start=1 in TX_IDLE at edge k: data_in latched, busy=1 and tx_line=0 from cycle k+1.
REQ-018 busy stays 1 for exactly N = (2+DATA_WIDTH+P)*BIT_CYCLES cycles (P=1 with PARITY_EN, else 0), then returns to 0 in TX_IDLE.
REQ-019 start while busy=1 is ignored; start held high through frame end starts a new frame on the first TX_IDLE cycle.
REQ-020 rx_line passes through a 2-flop synchroniser before any use.
REQ-021 RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_PARITY (PARITY_EN only), RX_STOP.
REQ-022 In RX_IDLE, synchronised low moves to RX_START; sample at BIT_CYCLES/2 cycles later; if high, treat as glitch and return to RX_IDLE with no flags.
REQ-023 Subsequent bits sampled every BIT_CYCLES cycles from the start-bit sample point.
REQ-024 Stop sample 1 and received=0: data_out updated, received=1 the next cycle.
REQ-025 Stop sample 1 and received=1: data_out unchanged, new word dropped, overrun set to 1.
REQ-026 Stop sample 0: frame_error pulses one cycle, data_out and received unchanged, RX waits for synchronised high before re-entering RX_IDLE.
REQ-027 processed=1 with received=1: received and overrun clear on the next cycle; processed with received=0 has no effect.
REQ-028 Frame completion and processed in the same cycle: the acknowledge applies to the old word, the new word is accepted, received stays 1, overrun not set.
REQ-029 TX and RX operate independently; full duplex allowed.

Reset
REQ-030 reset=1 at an edge forces both FSMs to idle mid-frame, with no flags raised for the aborted frame.
REQ-031 Reset values: busy=0, tx_line=1, data_out=0, received=0, frame_error=0, overrun=0, synchroniser flops=1.
REQ-032 reset overrides start and processed in the same cycle.

Configuration
REQ-033 Macro FPGA_LINK_PARITY_EN defined: an even-parity bit over the data is appended after the data bits and checked on receive.
REQ-034 A parity mismatch pulses frame_error and drops the word, exactly as a bad stop bit does.
REQ-035 Without FPGA_LINK_PARITY_EN: no parity bit, N=(2+DATA_WIDTH)*BIT_CYCLES, and no parity logic is instantiated.

Verification
REQ-036 Loopback tx_line->rx_line, defaults, transmit 45 -> busy high 40 cycles, received=1, data_out=45; processed -> received=0.
REQ-037 Loopback sequence 2,4,8,16,32,64,128,255,99,3, each acknowledged -> each data_out matches in order; overrun stays 0.
REQ-038 Transmit 7 and then 9 without processed -> data_out=7, overrun=1; processed -> received=0, overrun=0.
REQ-039 Drive rx_line with stop bit 0 for word 0xA5 -> frame_error one-cycle pulse, received stays 0; 2-cycle low glitch on rx_line -> no effect.
REQ-040 reset mid-frame of 0x3C -> next cycle tx_line=1, busy=0, no received; next transmit 0x81 succeeds.
REQ-041 FPGA_LINK_PARITY_EN with DATA_WIDTH=12: loopback 0xABC -> N=60 cycles, data_out=0xABC; flipped parity bit -> frame_error pulse.
